instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 33 +++
 rtl/instr_fetch_next_pc.sv | 53 +++++
 rtl/instr_fetch.sv | 100 ++++++++++
 tb/tb_instr_fetch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and constants for the instruction fetch unit
//
// Purpose : FSM state type, reset-PC default, MIPS-style opcode constants,
//           the decoder-control bundle and the branch-offset helper.
// Ports   : none (package).
package instr_fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  // Decoder controls for the held instruction, bundled for the next-PC unit.
  typedef struct packed {
    logic jr;
    logic jump;
    logic branch;
    logic nequal;
  } ctrl_t;

  // Sign-extended 16-bit word offset converted to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_next_pc.sv
// rtl/instr_fetch_next_pc.sv - combinational next-PC selection for the fetch unit
//
// Purpose : computes pc+4 and the address of the instruction that follows
//           the held one (Jr, jump, taken branch or sequential).
// Ports   : pc       in  32  address of the held instruction
//           inst     in  32  held instruction word
//           control  in  ctrl_t  jr/jump/branch/nequal for the held instruction
//           zero     in  1   ALU equality result
//           rs_data  in  32  register rs value (Jr target)
//           next_pc  out 32  selected successor address
//           pc4      out 32  pc+4 (wraps modulo 2^32)
module next_pc
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  ctrl_t       control,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output logic [31:0] pc4
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        branch_taken;

  // Opcode and the Jr low bits do not affect the target; the low bits are
  // reported separately by the top as the misalign flag.
  logic unused_bits;
  assign unused_bits = ^{inst[31:26], rs_data[1:0]};

  assign pc4           = pc + 32'd4;
  assign branch_target = pc4 + branch_offset(inst[15:0]);
  assign jump_target   = {pc4[31:28], inst[25:0], 2'b00};
  assign jr_target     = {rs_data[31:2], 2'b00};

  // beq takes on equal, bne on not-equal: NEqual inverts the sense of zero.
  assign branch_taken  = control.branch & (zero ^ control.nequal);

  always_comb begin
    next_pc = pc4;
    if (control.jr) begin
      next_pc = jr_target;
    end else if (control.jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - two-state instruction fetch unit with PC sequencing
//
// Purpose : fetches one instruction word at a time, holds it for the
//           decoder until downstream signals advance, then moves the PC.
// Ports   : clk, rst           clock, asynchronous active-high reset
//           im_req/im_addr     instruction-memory request and word address
//           im_ack/im_rdata    memory response
//           inst/inst_valid    held instruction to the decoder
//           opcode/funct       inst[31:26] / inst[5:0]
//           Jump/Branch/NEqual/Jr/zero/rs_data  decoder feedback for next PC
//           advance            held instruction completed
//           pc/link_addr       held instruction address / pc+4
//           retired            completed-instruction count (wraps)
//           misalign           sticky: a Jr target had nonzero low bits
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        NEqual,
  input  logic        Jr,
  input  logic        zero,
  input  logic [31:0] rs_data,
  input  logic        advance,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic [31:0] retired,
  output logic        misalign
);

  state_t      state;
  ctrl_t       ctrl;
  logic [31:0] npc;
  logic [31:0] pc4;

  assign ctrl = '{jr: Jr, jump: Jump, branch: Branch, nequal: NEqual};

  next_pc u_next_pc (
    .pc      (pc),
    .inst    (inst),
    .control (ctrl),
    .zero    (zero),
    .rs_data (rs_data),
    .next_pc (npc),
    .pc4     (pc4)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_valid <= 1'b0;
      retired    <= '0;
      misalign   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (im_ack) begin
            inst       <= im_rdata;
            inst_valid <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (advance) begin
            pc         <= npc;
            retired    <= retired + 32'd1;
            inst_valid <= 1'b0;
            state      <= FETCH;
            if (Jr && (rs_data[1:0] != 2'b00)) begin
              misalign <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // The request is gated by rst so it drops the instant reset is applied
  // and rises in the first cycle after release, without waiting an edge.
  assign im_req    = (state == FETCH) && !rst;
  assign im_addr   = pc;
  assign opcode    = inst[31:26];
  assign funct     = inst[5:0];
  assign link_addr = pc4;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        Jump = 1'b0;
  logic        Branch = 1'b0;
  logic        NEqual = 1'b0;
  logic        Jr = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] rs_data = '0;
  logic        advance = 1'b0;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic [31:0] retired;
  logic        misalign;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_ack     (im_ack),
    .im_rdata   (im_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .opcode     (opcode),
    .funct      (funct),
    .Jump       (Jump),
    .Branch     (Branch),
    .NEqual     (NEqual),
    .Jr         (Jr),
    .zero       (zero),
    .rs_data    (rs_data),
    .advance    (advance),
    .pc         (pc),
    .link_addr  (link_addr),
    .retired    (retired),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One FETCH cycle with an immediate ack; leaves the DUT in EXEC.
  task automatic do_fetch(input logic [31:0] word);
    im_ack   = 1'b1;
    im_rdata = word;
    tick();
    im_ack   = 1'b0;
    im_rdata = '0;
  endtask

  // One EXEC cycle with advance and the given controls; leaves DUT in FETCH.
  task automatic do_exec(input logic jr_i, input logic jump_i, input logic br_i,
                         input logic ne_i, input logic zero_i, input logic [31:0] rs_i);
    Jr = jr_i; Jump = jump_i; Branch = br_i; NEqual = ne_i; zero = zero_i; rs_data = rs_i;
    advance = 1'b1;
    tick();
    advance = 1'b0;
    Jr = 1'b0; Jump = 1'b0; Branch = 1'b0; NEqual = 1'b0; zero = 1'b0; rs_data = '0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++; if (im_req !== 1'b0) begin n_bad++; $display("FAIL rst_im_req: got %b want 0", im_req); end
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", pc); end
    n_cmp++; if (inst !== 32'h0 || inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_inst: got %h/%b want 0/0", inst, inst_valid); end
    n_cmp++; if (retired !== 32'h0 || misalign !== 1'b0) begin n_bad++; $display("FAIL rst_cnt: got %h/%b want 0/0", retired, misalign); end
    rst = 1'b0;
    #1;
    n_cmp++; if (im_req !== 1'b1 || im_addr !== 32'h0) begin n_bad++; $display("FAIL rst_release: got %b/%h want 1/0", im_req, im_addr); end
  endtask

  task automatic test_straight_line();
    im_ack   = 1'b1;
    advance  = 1'b1;
    im_rdata = 32'h0000_0020;
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (im_req !== 1'b1 || im_addr !== 32'(4 * i)) begin n_bad++; $display("FAIL seq_addr[%0d]: got %b/%h want 1/%h", i, im_req, im_addr, 32'(4 * i)); end
      n_cmp++; if (retired !== 32'(i)) begin n_bad++; $display("FAIL seq_retired[%0d]: got %0d want %0d", i, retired, i); end
      tick();
      n_cmp++; if (im_req !== 1'b0 || inst_valid !== 1'b1 || funct !== 6'h20) begin n_bad++; $display("FAIL seq_exec[%0d]: req=%b valid=%b funct=%h want 0/1/20", i, im_req, inst_valid, funct); end
      tick();
    end
    im_ack   = 1'b0;
    advance  = 1'b0;
    im_rdata = '0;
  endtask

  task automatic test_branch();
    do_reset();
    do_fetch(32'h0); do_exec(0, 0, 0, 0, 0, 0);
    do_fetch(32'h0); do_exec(0, 0, 0, 0, 0, 0);
    do_fetch(32'h1000_FFFF);
    n_cmp++; if (opcode !== 6'h04 || pc !== 32'h8) begin n_bad++; $display("FAIL beq_held: opcode=%h pc=%h want 04/8", opcode, pc); end
    do_exec(0, 0, 1, 0, 1, 0);
    n_cmp++; if (im_addr !== 32'h8) begin n_bad++; $display("FAIL beq_taken: got %h want 8", im_addr); end
    do_fetch(32'h1000_FFFF);
    do_exec(0, 0, 1, 0, 0, 0);
    n_cmp++; if (im_addr !== 32'hC) begin n_bad++; $display("FAIL beq_not_taken: got %h want c", im_addr); end
    do_reset();
    do_fetch(32'h0); do_exec(0, 0, 0, 0, 0, 0);
    do_fetch(32'h0); do_exec(0, 0, 0, 0, 0, 0);
    do_fetch(32'h1400_FFFF);
    do_exec(0, 0, 1, 1, 1, 0);
    n_cmp++; if (im_addr !== 32'hC) begin n_bad++; $display("FAIL bne_not_taken: got %h want c", im_addr); end
    do_fetch(32'h1400_FFFF);
    do_exec(0, 0, 1, 1, 0, 0);
    n_cmp++; if (im_addr !== 32'hC) begin n_bad++; $display("FAIL bne_taken: got %h want c", im_addr); end
    do_fetch(32'h1000_0003);
    do_exec(0, 0, 1, 0, 1, 0);
    n_cmp++; if (im_addr !== 32'h1C) begin n_bad++; $display("FAIL beq_fwd: got %h want 1c", im_addr); end
  endtask

  task automatic test_jump();
    do_reset();
    do_fetch(32'h0);
    do_exec(1, 0, 0, 0, 0, 32'h1000_0000);
    n_cmp++; if (im_addr !== 32'h1000_0000 || misalign !== 1'b0) begin n_bad++; $display("FAIL jr_aligned: got %h/%b want 10000000/0", im_addr, misalign); end
    do_fetch(32'h0C00_0010);
    n_cmp++; if (link_addr !== 32'h1000_0004) begin n_bad++; $display("FAIL jal_link: got %h want 10000004", link_addr); end
    do_exec(0, 1, 0, 0, 0, 0);
    n_cmp++; if (im_addr !== 32'h1000_0040) begin n_bad++; $display("FAIL jal_target: got %h want 10000040", im_addr); end
    do_fetch(32'h0800_0010);
    do_exec(0, 1, 0, 0, 0, 0);
    n_cmp++; if (im_addr !== 32'h1000_0040) begin n_bad++; $display("FAIL j_target: got %h want 10000040", im_addr); end
    do_fetch(32'h1000_0001);
    do_exec(1, 1, 1, 0, 1, 32'h0000_0200);
    n_cmp++; if (im_addr !== 32'h0000_0200) begin n_bad++; $display("FAIL prio_jr: got %h want 200", im_addr); end
    do_fetch(32'h0800_0008);
    do_exec(0, 1, 1, 0, 1, 0);
    n_cmp++; if (im_addr !== 32'h0000_0020) begin n_bad++; $display("FAIL prio_jump: got %h want 20", im_addr); end
    do_fetch(32'h0);
    do_exec(1, 0, 0, 0, 0, 32'hFFFF_FFFC);
    do_fetch(32'h0);
    n_cmp++; if (link_addr !== 32'h0) begin n_bad++; $display("FAIL pc4_wrap: got %h want 0", link_addr); end
    do_exec(0, 0, 0, 0, 0, 0);
    n_cmp++; if (im_addr !== 32'h0) begin n_bad++; $display("FAIL pc_wrap: got %h want 0", im_addr); end
  endtask

  task automatic test_misalign();
    do_reset();
    do_fetch(32'h0);
    do_exec(1, 0, 0, 0, 0, 32'h0000_0103);
    n_cmp++; if (im_addr !== 32'h100 || misalign !== 1'b1) begin n_bad++; $display("FAIL jr_misalign: got %h/%b want 100/1", im_addr, misalign); end
    do_fetch(32'h0); do_exec(0, 0, 0, 0, 0, 0);
    do_fetch(32'h0); do_exec(1, 0, 0, 0, 0, 32'h0000_0200);
    n_cmp++; if (misalign !== 1'b1 || im_addr !== 32'h200) begin n_bad++; $display("FAIL misalign_sticky: got %b/%h want 1/200", misalign, im_addr); end
    do_reset();
    n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL misalign_clear: got %b want 0", misalign); end
  endtask

  task automatic test_stall();
    do_reset();
    do_fetch(32'h0); do_exec(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      advance = i[0];
      tick();
      n_cmp++; if (im_req !== 1'b1 || im_addr !== 32'h4 || pc !== 32'h4 || retired !== 32'd1) begin n_bad++; $display("FAIL stall[%0d]: req=%b addr=%h pc=%h ret=%0d want 1/4/4/1", i, im_req, im_addr, pc, retired); end
    end
    advance = 1'b0;
    do_fetch(32'hAAAA_0001);
    im_ack   = 1'b1;
    im_rdata = 32'h5555_0002;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (inst !== 32'hAAAA_0001 || im_req !== 1'b0 || pc !== 32'h4) begin n_bad++; $display("FAIL exec_hold[%0d]: inst=%h req=%b pc=%h want aaaa0001/0/4", i, inst, im_req, pc); end
    end
    im_ack   = 1'b0;
    im_rdata = '0;
    do_exec(0, 0, 0, 0, 0, 0);
    n_cmp++; if (im_addr !== 32'h8 || retired !== 32'd2) begin n_bad++; $display("FAIL after_stall: got %h/%0d want 8/2", im_addr, retired); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    do_fetch(32'h0);
    do_exec(1, 0, 0, 0, 0, 32'h0000_0040);
    tick();
    n_cmp++; if (im_req !== 1'b1 || im_addr !== 32'h40) begin n_bad++; $display("FAIL pre_reset: got %b/%h want 1/40", im_req, im_addr); end
    rst = 1'b1;
    #1;
    n_cmp++; if (im_req !== 1'b0 || pc !== 32'h0) begin n_bad++; $display("FAIL reset_async: got %b/%h want 0/0", im_req, pc); end
    im_ack   = 1'b1;
    im_rdata = 32'hDEAD_BEEF;
    tick();
    im_ack   = 1'b0;
    im_rdata = '0;
    rst = 1'b0;
    #1;
    n_cmp++; if (im_req !== 1'b1 || im_addr !== 32'h0 || retired !== 32'h0) begin n_bad++; $display("FAIL reset_release: got %b/%h/%0d want 1/0/0", im_req, im_addr, retired); end
    n_cmp++; if (inst !== 32'h0 || inst_valid !== 1'b0) begin n_bad++; $display("FAIL ack_discarded: got %h/%b want 0/0", inst, inst_valid); end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_branch();
    test_jump();
    test_misalign();
    test_stall();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
